// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Pixel-clock video timing generator with registered, aligned
//               sync/DE/RGB outputs and an internal 8-bar colour pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int   H_SYNC   = 40,
    parameter int   H_BACK   = 220,
    parameter int   H_DISP   = 1280,
    parameter int   H_FRONT  = 110,
    parameter int   V_SYNC   = 5,
    parameter int   V_BACK   = 20,
    parameter int   V_DISP   = 720,
    parameter int   V_FRONT  = 5,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        pattern_en,
    input  logic [23:0] pixel_data,
    output logic        data_req,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        video_hsync,
    output logic        video_vsync,
    output logic        video_de,
    output logic [23:0] video_rgb,
    output logic        frame_start
);

    localparam logic [11:0] C_H_TOTAL   = 12'(H_SYNC + H_BACK + H_DISP + H_FRONT);
    localparam logic [11:0] C_V_TOTAL   = 12'(V_SYNC + V_BACK + V_DISP + V_FRONT);
    localparam logic [11:0] C_H_SYNC    = 12'(H_SYNC);
    localparam logic [11:0] C_V_SYNC    = 12'(V_SYNC);
    localparam logic [11:0] C_H_ACT     = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] C_V_ACT     = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] C_H_END     = 12'(H_SYNC + H_BACK + H_DISP - 1);
    localparam logic [11:0] C_V_END     = 12'(V_SYNC + V_BACK + V_DISP - 1);
    localparam logic [11:0] C_REQ_FIRST = 12'(H_SYNC + H_BACK - 1);
    localparam logic [11:0] C_REQ_LAST  = 12'(H_SYNC + H_BACK + H_DISP - 2);
    localparam logic [11:0] C_BAR_LAST  = 12'(H_DISP / 8 - 1);

    logic [11:0] r_h_cnt;
    logic [11:0] r_v_cnt;
    logic [11:0] r_bar_pix;
    logic [2:0]  r_bar_idx;

    logic        w_h_act;
    logic        w_v_act;
    logic        w_req;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic [23:0] w_bar_rgb;
    logic [23:0] w_src_rgb;

    assign w_h_act  = (r_h_cnt >= C_H_ACT) && (r_h_cnt <= C_H_END);
    assign w_v_act  = (r_v_cnt >= C_V_ACT) && (r_v_cnt <= C_V_END);
    assign w_h_wrap = (r_h_cnt == C_H_TOTAL - 12'd1);
    assign w_v_wrap = (r_v_cnt == C_V_TOTAL - 12'd1);

    // Requests lead the active window by one pixel to cover the source latency.
    assign w_req      = w_v_act && (r_h_cnt >= C_REQ_FIRST) && (r_h_cnt <= C_REQ_LAST);
    assign data_req   = w_req;
    assign pixel_xpos = w_req ? 11'(r_h_cnt - C_REQ_FIRST) : 11'd0;
    assign pixel_ypos = w_req ? 11'(r_v_cnt - C_V_ACT) : 11'd0;

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? 12'd0 : r_v_cnt + 12'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 12'd1;
        end
    end

    // Bar index tracks the column currently on r_h_cnt; it is primed the
    // cycle before the first active pixel so index 0 lines up with H_ACT.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_bar_pix <= '0;
            r_bar_idx <= '0;
        end else if (r_h_cnt == C_REQ_FIRST) begin
            r_bar_pix <= '0;
            r_bar_idx <= '0;
        end else if (w_h_act) begin
            if (r_bar_pix == C_BAR_LAST) begin
                r_bar_pix <= '0;
                r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
                r_bar_pix <= r_bar_pix + 12'd1;
            end
        end
    end

    always_comb begin
        w_bar_rgb = 24'h000000;
        case (r_bar_idx)
            3'd0:    w_bar_rgb = 24'hFFFFFF;
            3'd1:    w_bar_rgb = 24'hFFFF00;
            3'd2:    w_bar_rgb = 24'h00FFFF;
            3'd3:    w_bar_rgb = 24'h00FF00;
            3'd4:    w_bar_rgb = 24'hFF00FF;
            3'd5:    w_bar_rgb = 24'hFF0000;
            3'd6:    w_bar_rgb = 24'h0000FF;
            default: w_bar_rgb = 24'h000000;
        endcase
    end

    assign w_src_rgb = pattern_en ? w_bar_rgb : pixel_data;

    always_ff @(posedge pclk) begin
        if (reset) begin
            video_hsync <= ~SYNC_POL;
            video_vsync <= ~SYNC_POL;
            video_de    <= 1'b0;
            video_rgb   <= 24'h0;
            frame_start <= 1'b0;
        end else begin
            video_hsync <= (r_h_cnt < C_H_SYNC) ? SYNC_POL : ~SYNC_POL;
            video_vsync <= (r_v_cnt < C_V_SYNC) ? SYNC_POL : ~SYNC_POL;
            video_de    <= w_h_act & w_v_act;
            video_rgb   <= (w_h_act & w_v_act) ? w_src_rgb : 24'h0;
            frame_start <= (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Scoreboard bench for video_timing_gen (small-timing instance
//               plus a full-width instance for the colour-bar pattern).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Instance A: H 2/2/8/2 (14), V 1/1/4/1 (7), fed by a {ypos,xpos} source.
    logic        reset_a      = 1'b1;
    logic        pattern_en_a = 1'b0;
    logic [23:0] pixel_data_a = 24'h0;
    logic        data_req_a, hsync_a, vsync_a, de_a, fs_a;
    logic [10:0] xpos_a, ypos_a;
    logic [23:0] rgb_a;

    video_timing_gen #(
        .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1), .SYNC_POL(1'b1)
    ) u_dut_a (
        .pclk(pclk), .reset(reset_a), .pattern_en(pattern_en_a), .pixel_data(pixel_data_a),
        .data_req(data_req_a), .pixel_xpos(xpos_a), .pixel_ypos(ypos_a),
        .video_hsync(hsync_a), .video_vsync(vsync_a), .video_de(de_a),
        .video_rgb(rgb_a), .frame_start(fs_a)
    );

    always @(posedge pclk) pixel_data_a <= {2'b00, ypos_a, xpos_a};

    // Instance B: default horizontal timing, short vertical timing.
    logic        reset_b      = 1'b1;
    logic        pattern_en_b = 1'b1;
    logic [23:0] pixel_data_b = 24'hA5C3E1;
    logic        data_req_b, hsync_b, vsync_b, de_b, fs_b;
    logic [10:0] xpos_b, ypos_b;
    logic [23:0] rgb_b;

    video_timing_gen #(
        .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1)
    ) u_dut_b (
        .pclk(pclk), .reset(reset_b), .pattern_en(pattern_en_b), .pixel_data(pixel_data_b),
        .data_req(data_req_b), .pixel_xpos(xpos_b), .pixel_ypos(ypos_b),
        .video_hsync(hsync_b), .video_vsync(vsync_b), .video_de(de_b),
        .video_rgb(rgb_b), .frame_start(fs_b)
    );

    logic [23:0] sb_a[$];
    logic [23:0] sb_b[$];
    logic [23:0] bars [8];
    logic        rst_prev_a = 1'b1;
    logic        rst_prev_b = 1'b1;
    logic        done_a = 1'b0;
    logic        done_b = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    always @(posedge pclk) begin
        rst_prev_a <= reset_a;
        rst_prev_b <= reset_b;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frames_a(input int frames);
        for (int f = 0; f < frames; f++)
            for (int y = 0; y < 4; y++)
                for (int x = 0; x < 8; x++)
                    sb_a.push_back({2'b00, 11'(y), 11'(x)});
    endtask

    initial begin : stim_a
        push_frames_a(2);
        repeat (4) @(posedge pclk);
        #1 reset_a = 1'b0;
        repeat (158) @(posedge pclk);
        #1 reset_a = 1'b1;
        repeat (5) @(posedge pclk);
        #1;
        sb_a.delete();
        push_frames_a(2);
        reset_a = 1'b0;
        repeat (197) @(posedge pclk);
        #1 done_a = 1'b1;
    end

    initial begin : stim_b
        bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
        bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
        for (int x = 0; x < 1280; x++) sb_b.push_back(bars[x / 160]);
        // Second active line: source switched to pixel_data for columns 100..699.
        for (int x = 0; x < 1280; x++)
            sb_b.push_back((x >= 100 && x < 700) ? 24'hA5C3E1 : bars[x / 160]);
        repeat (3) @(posedge pclk);
        #1 reset_b = 1'b0;
        repeat (5310) @(posedge pclk);
        #1 pattern_en_b = 1'b0;
        repeat (600) @(posedge pclk);
        #1 pattern_en_b = 1'b1;
        repeat (591) @(posedge pclk);
        #1 done_b = 1'b1;
    end

    initial begin : monitor
        int k_a, k_b, req_cnt, n, h, v, h2, v2;
        logic [3:0]  e_sync;
        logic [22:0] e_req;
        logic [2:0]  e_sync_b;
        logic [23:0] exp_rgb;
        k_a = 0; k_b = 0; req_cnt = 0;
        forever begin
            @(negedge pclk);
            if (!done_a) begin
                if (rst_prev_a) begin
                    check("reset_a", 64'({hsync_a, vsync_a, de_a, fs_a, data_req_a, xpos_a, ypos_a, rgb_a}), 64'd0);
                    k_a = 0;
                    req_cnt = 0;
                end else begin
                    k_a++;
                    n = k_a - 1;
                    h = n % 14;
                    v = (n / 14) % 7;
                    e_sync = {h < 2, v == 0, (h >= 4 && h <= 11 && v >= 2 && v <= 5), (n % 98) == 0};
                    check("sync_a{hs,vs,de,fs}", 64'({hsync_a, vsync_a, de_a, fs_a}), 64'(e_sync));
                    h2 = k_a % 14;
                    v2 = (k_a / 14) % 7;
                    if (h2 >= 3 && h2 <= 10 && v2 >= 2 && v2 <= 5)
                        e_req = {1'b1, 11'(h2 - 3), 11'(v2 - 2)};
                    else
                        e_req = '0;
                    check("req_a{req,x,y}", 64'({data_req_a, xpos_a, ypos_a}), 64'(e_req));
                    if (data_req_a) req_cnt++;
                    if (k_a % 98 == 0) begin
                        check("req_count_a", 64'(req_cnt), 64'd32);
                        req_cnt = 0;
                    end
                    if (de_a) begin
                        check("rgb_a_available", 64'(sb_a.size() > 0), 64'd1);
                        if (sb_a.size() > 0) begin
                            exp_rgb = sb_a.pop_front();
                            check("rgb_a", 64'(rgb_a), 64'(exp_rgb));
                        end
                    end else begin
                        check("rgb_a_blank", 64'(rgb_a), 64'd0);
                    end
                end
            end
            if (!done_b) begin
                if (rst_prev_b) begin
                    check("reset_b", 64'({hsync_b, vsync_b, de_b, fs_b, rgb_b}), 64'd0);
                    k_b = 0;
                end else begin
                    k_b++;
                    n = k_b - 1;
                    h = n % 1650;
                    v = (n / 1650) % 7;
                    e_sync_b = {h < 40, v == 0, (h >= 260 && h <= 1539 && v >= 2 && v <= 5)};
                    check("sync_b{hs,vs,de}", 64'({hsync_b, vsync_b, de_b}), 64'(e_sync_b));
                    if (de_b) begin
                        check("rgb_b_available", 64'(sb_b.size() > 0), 64'd1);
                        if (sb_b.size() > 0) begin
                            exp_rgb = sb_b.pop_front();
                            check("rgb_b", 64'(rgb_b), 64'(exp_rgb));
                        end
                    end else begin
                        check("rgb_b_blank", 64'(rgb_b), 64'd0);
                    end
                end
            end
            if (done_a && done_b) begin
                check("sb_a_drained", 64'(sb_a.size()), 64'd0);
                check("sb_b_drained", 64'(sb_b.size()), 64'd0);
                $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
                $finish;
            end
        end
    end

endmodule
`default_nettype wire
